// File: rtl/decode_stage.sv
// decode_stage: instruction decode stage feeding alu_stage.
//
// Holds the fetched instruction in an instruction register (IR), splits it into
// the fields alu_stage latches, reads the 8x16 register file owned by this stage,
// and resolves RAW hazards. Two sources are checked before the register file:
// the forward from the ALU stage output, then the same-cycle writeback.
// All outputs are combinational from the IR, the register file and the forward
// inputs, so alu_stage captures them on its next clock edge.
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   asynchronous, active-low
//   enable        in   stage advance (shared with alu_stage)
//   inst_in       in   [15:0] instruction from fetch
//   inst_valid_in in   inst_in holds a real instruction
//   wb_data       in   [15:0] writeback data
//   wb_adr        in   [2:0]  writeback register address
//   wb_we         in   writeback write enable
//   ex_result     in   [15:0] alu_stage result (forward source)
//   ex_dest       in   [2:0]  alu_stage destination register
//   ex_we         in   alu_stage write enable
//   regA, regB    out  [15:0] operands
//   cop           out  [3:0]  opcode
//   destReg_adr   out  [2:0]  destination register
//   we            out  destination write enable (valid and not NOP)
//   regA_adr      out  [2:0]  source A field
//   regB_adr      out  [2:0]  source B field
//   inst_freeBits out  [2:0]  low instruction bits
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] inst_in,
  input  logic        inst_valid_in,
  input  logic [15:0] wb_data,
  input  logic [2:0]  wb_adr,
  input  logic        wb_we,
  input  logic [15:0] ex_result,
  input  logic [2:0]  ex_dest,
  input  logic        ex_we,
  output logic [15:0] regA,
  output logic [15:0] regB,
  output logic [3:0]  cop,
  output logic [2:0]  destReg_adr,
  output logic        we,
  output logic [2:0]  regA_adr,
  output logic [2:0]  regB_adr,
  output logic [2:0]  inst_freeBits
);

  localparam logic [3:0] CopNop = 4'b1111;

  logic [15:0] instReg;
  logic        instValid;
  logic [15:0] regFile [8];

  // Instruction register: loads on enable, holds during a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instReg   <= 16'h0000;
      instValid <= 1'b0;
    end else if (enable) begin
      instReg   <= inst_in;
      instValid <= inst_valid_in;
    end
  end

  // Register file: writeback is independent of enable so WB keeps draining
  // while this stage is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        regFile[i] <= 16'h0000;
      end
    end else if (wb_we) begin
      regFile[wb_adr] <= wb_data;
    end
  end

  // Field split; fields pass through even when the IR is not valid.
  always_comb begin
    cop           = instReg[15:12];
    destReg_adr   = instReg[11:9];
    regA_adr      = instReg[8:6];
    regB_adr      = instReg[5:3];
    inst_freeBits = instReg[2:0];
  end

  // Operand select: the EX forward is the younger value, so it beats the WB
  // bypass; the WB bypass gives write-through on a same-cycle read.
  function automatic logic [15:0] selectOperand(
    input logic [2:0]  src,
    input logic        fwdEx,
    input logic [2:0]  fwdExAdr,
    input logic [15:0] fwdExData,
    input logic        fwdWb,
    input logic [2:0]  fwdWbAdr,
    input logic [15:0] fwdWbData,
    input logic [15:0] fileData
  );
    if (fwdEx && (fwdExAdr == src)) begin
      return fwdExData;
    end else if (fwdWb && (fwdWbAdr == src)) begin
      return fwdWbData;
    end else begin
      return fileData;
    end
  endfunction

  logic [15:0] operandA;
  logic [15:0] operandB;

  always_comb begin
    operandA = selectOperand(instReg[8:6], ex_we, ex_dest, ex_result,
                             wb_we, wb_adr, wb_data, regFile[instReg[8:6]]);
    operandB = selectOperand(instReg[5:3], ex_we, ex_dest, ex_result,
                             wb_we, wb_adr, wb_data, regFile[instReg[5:3]]);
  end

  // An empty IR slot presents zero operands and no write.
  always_comb begin
    regA = instValid ? operandA : 16'h0000;
    regB = instValid ? operandB : 16'h0000;
    we   = instValid && (instReg[15:12] != CopNop);
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage feeding `alu_stage`. Holds the fetched instruction in an instruction register, splits it into the fields `alu_stage` latches, reads the 8×16 register file it owns, and resolves RAW hazards by forwarding from the ALU stage output and bypassing the same-cycle writeback. All outputs are combinational from the instruction register, register file and forward inputs, so `alu_stage` captures them on its next clock edge with no bubbles.

## Interface
- No parameters; widths are fixed (16-bit data, 8 registers, 4-bit `cop`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: stage advance; same signal as `alu_stage.enable`.
- `inst_in` in 16: instruction from fetch.
- `inst_valid_in` in 1: `inst_in` holds a real instruction.
- `wb_data` in 16: writeback data.
- `wb_adr` in 3: writeback register address.
- `wb_we` in 1: writeback write enable.
- `ex_result` in 16: `alu_stage.alu_result`.
- `ex_dest` in 3: `alu_stage.destReg_adr_output`.
- `ex_we` in 1: `alu_stage.we_output`.
- `regA` out 16: operand A.
- `regB` out 16: operand B.
- `cop` out 4: opcode.
- `destReg_adr` out 3: destination register.
- `we` out 1: destination write enable.
- `regA_adr` out 3: source A field.
- `regB_adr` out 3: source B field.
- `inst_freeBits` out 3: low instruction bits.

## Operation
- Instruction format: `[15:12]` cop, `[11:9]` dest, `[8:6]` srcA, `[5:3]` srcB, `[2:0]` free bits. `cop`=0011 uses `{srcA,srcB,free}` as a 9-bit immediate in `alu_stage`. The fields are passed through unchanged.
- Instruction register (IR, 16 bits plus a valid bit):
  - At a rising edge with `enable`=1, it loads `inst_in` / `inst_valid_in`.
  - With `enable`=0 it holds.
- Register file (8×16):
  - At a rising edge with `wb_we`=1, `reg[wb_adr]` ← `wb_data`.
  - Writes happen regardless of `enable`.
  - r0 is an ordinary register.
- Operand A, in priority order (first match wins):
  1. `ex_we`=1 and `ex_dest`=srcA → `ex_result`.
  2. `wb_we`=1 and `wb_adr`=srcA → `wb_data`.
  3. Otherwise → `reg[srcA]`.
- Operand B: same priority chain on srcB. It is computed for every `cop`, including 0011; `alu_stage` ignores it there.
- `we` = IR valid AND `cop`≠1111. 1111 is the NOP opcode.
- When IR valid=0:
  - `regA`=`regB`=0 and `we`=0.
  - Field outputs still reflect the IR contents.

## Timing
- Reset asserted: IR ← 0 and valid ← 0, all 8 registers ← 0.
  - Outputs during reset: `regA`=`regB`=0, `cop`=0, `destReg_adr`=0, `we`=0, address and free-bit fields = 0.
- Reset asserted mid-operation clears the IR immediately (asynchronous) and discards any pending write in that cycle.
- Latency:
  - An instruction presented at edge N is decoded during cycle N..N+1.
  - `alu_stage` captures it at edge N+1.
  - Its result appears on `ex_*` during N+1..N+2.
- Back-to-back dependent instructions are handled without stalls:
  - Distance 1: resolved by the EX forward.
  - Distance 2: resolved by the WB bypass.
  - Distance 3 or more: read from the register file.
- Simultaneous events:
  - If EX and WB both match a source, EX wins.
  - If WB writes address X in the same cycle that X is read, the read returns `wb_data` (write-through).
- `enable`=0 for k cycles freezes the outputs, provided the `ex_*` inputs are also frozen (which holds because `alu_stage` shares `enable`).
- Register-file writes from WB continue during a stall.

## Test plan
- Reset check: drive `reset`=0 while `inst_valid_in`=1 and `ex_we`=1. Required: all outputs are 0 and `we`=0. After release with no writes, a valid `inst_in`=16'h0A53 (cop 0, dest 5, srcA 1, srcB 2, free 3) gives `regA`=`regB`=0 and `we`=1.
- Writeback then read: write r3 ← 16'h1234 via `wb_*`, then two cycles later decode srcA=3. Required: `regA`=16'h1234.
- Forward priority: same cycle, `ex_dest`=2 with `ex_result`=16'hAAAA and `wb_adr`=2 with `wb_data`=16'h5555, decoding srcA=srcB=2. Required: `regA`=`regB`=16'hAAAA. With `ex_we`=0, both are 16'h5555. At the following edge, `reg[2]` holds 16'h5555.
- Immediate and NOP:
  - `inst_in`=16'h3FFF. Required: `cop`=3, `regA_adr`=7, `regB_adr`=7, `inst_freeBits`=7, `we`=1.
  - `inst_in`=16'hF000. Required: `we`=0.
  - `inst_valid_in`=0. Required: `we`=0 and operands 0.
- Stall: load instruction 16'h1249, hold `enable`=0 for 3 cycles while changing `inst_in`. Required: field outputs stay at 16'h1249's fields. A `wb_*` write to r1 during the stall is visible in `regA` the same cycle (bypass) and after it (register file).
